// File: rtl/redun_mont_pkg.sv
// Shared types and constants for the redundant-form Montgomery squaring sequencer.
package redun_mont_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SQ,
    LO,
    HI,
    DONE
  } state_t;

  localparam int CTL_W = 3;

  localparam logic [CTL_W-1:0] CTL_SQ = 3'b001;
  localparam logic [CTL_W-1:0] CTL_LO = 3'b010;
  localparam logic [CTL_W-1:0] CTL_HI = 3'b100;

endpackage

// File: rtl/redun_mont_seq_if.sv
// Host handshake plus multiplier operand/result bus of the squaring sequencer.
interface redun_mont_seq_if
  import redun_mont_pkg::*;
#(
  parameter int NUM_ELEMENTS = 33,
  parameter int DSP_BIT_LEN  = 17,
  parameter int ITER_W       = 32
);

  localparam int VW = NUM_ELEMENTS * DSP_BIT_LEN;

  logic              i_start;
  logic [ITER_W-1:0] i_iter;
  logic [VW-1:0]     i_sq;
  logic [VW-1:0]     i_modulus;
  logic [VW-1:0]     i_mod_inv;
  logic              o_busy;
  logic              o_done;
  logic [VW-1:0]     o_sq;
  logic [CTL_W-1:0]  o_mul_ctl;
  logic [VW-1:0]     o_mul_a;
  logic [VW-1:0]     o_mul_b;
  logic [VW-1:0]     o_mul_add;
  logic [2*VW-1:0]   i_mul_dat;

  modport slave (
    input  i_start, i_iter, i_sq, i_modulus, i_mod_inv, i_mul_dat,
    output o_busy, o_done, o_sq, o_mul_ctl, o_mul_a, o_mul_b, o_mul_add
  );

  modport master (
    output i_start, i_iter, i_sq, i_modulus, i_mod_inv, i_mul_dat,
    input  o_busy, o_done, o_sq, o_mul_ctl, o_mul_a, o_mul_b, o_mul_add
  );

endinterface

// File: rtl/redun_mont_phase_cnt.sv
// Modulo-(MUL_LAT+1) phase timer: reloads on clear, flags the terminal count as last_o.
module redun_mont_phase_cnt #(
  parameter int MUL_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr_i,
  output logic last_o
);

  localparam int PW = $clog2(MUL_LAT + 1);
  localparam logic [PW-1:0] LOAD = PW'(MUL_LAT);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - PW'(1);
    if (clr_i || (cnt_q == '0)) begin
      cnt_d = LOAD;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/redun_mont_seq.sv
// Runs repeated redundant Montgomery squarings through an external multiplier.
// state | meaning
// IDLE  | wait for i_start; multiplier parked in square mode with zero operands
// SQ    | sq*sq, capture T_lo / T_hi
// LO    | T_lo*N' mod R, capture m
// HI    | high half of m*M + T_hi, capture new sq, count down
// DONE  | one-cycle o_done pulse
module redun_mont_seq
  import redun_mont_pkg::*;
#(
  parameter int NUM_ELEMENTS = 33,
  parameter int DSP_BIT_LEN  = 17,
  parameter int WORD_LEN     = 16,
  parameter int MUL_LAT      = 1,
  parameter int ITER_W       = 32
) (
  input logic             i_clk,
  input logic             i_rst_n,
  redun_mont_seq_if.slave bus
);

  localparam int N  = NUM_ELEMENTS;
  localparam int D  = DSP_BIT_LEN;
  localparam int VW = N * D;
  // keeps m below R by dropping the redundant bits of its top word
  localparam logic [VW-1:0] M_MASK = {VW{1'b1}} >> (DSP_BIT_LEN - WORD_LEN);

  state_t            state_q, state_d;
  logic [VW-1:0]     sq_q, sq_d;
  logic [VW-1:0]     t_lo_q, t_lo_d;
  logic [VW-1:0]     t_hi_q, t_hi_d;
  logic [VW-1:0]     m_q, m_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;

  logic              ph_last;
  logic [VW-1:0]     dat_lo, dat_hi, dat_rev;
  logic [CTL_W-1:0]  mul_ctl;
  logic [VW-1:0]     mul_a, mul_b, mul_add;

  assign dat_lo = bus.i_mul_dat[VW-1:0];
  assign dat_hi = bus.i_mul_dat[2*VW-1:VW];

  // high-half result arrives most-significant word first
  always_comb begin
    dat_rev = '0;
    for (int k = 0; k < N; k++) begin
      dat_rev[k*D +: D] = dat_lo[(N-1-k)*D +: D];
    end
  end

  redun_mont_phase_cnt #(.MUL_LAT(MUL_LAT)) u_phase_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr_i   (state_d != state_q),
    .last_o  (ph_last)
  );

  always_comb begin
    state_d = state_q;
    sq_d    = sq_q;
    t_lo_d  = t_lo_q;
    t_hi_d  = t_hi_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    mul_ctl = CTL_SQ;
    mul_a   = '0;
    mul_b   = '0;
    mul_add = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          sq_d    = bus.i_sq;
          cnt_d   = bus.i_iter;
          state_d = (bus.i_iter == '0) ? DONE : SQ;
        end
      end
      SQ: begin
        mul_a = sq_q;
        mul_b = sq_q;
        if (ph_last) begin
          t_lo_d  = dat_lo;
          t_hi_d  = dat_hi;
          state_d = LO;
        end
      end
      LO: begin
        mul_ctl = CTL_LO;
        mul_a   = t_lo_q;
        mul_b   = bus.i_mod_inv;
        if (ph_last) begin
          m_d     = dat_lo & M_MASK;
          state_d = HI;
        end
      end
      HI: begin
        mul_ctl = CTL_HI;
        mul_a   = m_q;
        mul_b   = bus.i_modulus;
        mul_add = t_hi_q;
        if (ph_last) begin
          sq_d    = dat_rev;
          cnt_d   = cnt_q - ITER_W'(1);
          state_d = (cnt_q == ITER_W'(1)) ? DONE : SQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sq_q    <= '0;
      t_lo_q  <= '0;
      t_hi_q  <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sq_q    <= sq_d;
      t_lo_q  <= t_lo_d;
      t_hi_q  <= t_hi_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_done    = (state_q == DONE);
  assign bus.o_sq      = sq_q;
  assign bus.o_mul_ctl = mul_ctl;
  assign bus.o_mul_a   = mul_a;
  assign bus.o_mul_b   = mul_b;
  assign bus.o_mul_add = mul_add;

endmodule

// File: tb/tb_redun_mont_seq.sv
// Bench for redun_mont_seq: behavioural multiplier, bignum Montgomery reference,
// scoreboard queue of expected runs checked by an independent monitor.
module tb_redun_mont_seq;
  import redun_mont_pkg::*;

  localparam int N       = 4;
  localparam int D       = 17;
  localparam int WL      = 16;
  localparam int L       = 2;
  localparam int IW      = 32;
  localparam int VW      = N * D;
  localparam int BW      = 256;
  localparam int RUN_LEN = 3 * (L + 1);

  typedef logic [BW-1:0] big_t;
  typedef struct {
    int unsigned s_cyc;
    int unsigned d_cyc;
    big_t        m;
    big_t        want;
  } exp_t;

  localparam big_t R  = big_t'(1) << (WL * N);
  localparam big_t RM = R - big_t'(1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          chk_idle = 1'b0;
  exp_t        sb[$];
  big_t        mod_m, nprime, rinv;
  logic [2*VW-1:0] pipe [L];

  redun_mont_seq_if #(.NUM_ELEMENTS(N), .DSP_BIT_LEN(D), .ITER_W(IW)) bus ();

  redun_mont_seq #(
    .NUM_ELEMENTS(N), .DSP_BIT_LEN(D), .WORD_LEN(WL), .MUL_LAT(L), .ITER_W(IW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [D-1:0] word_of(input big_t p, input int k, input bit top);
    big_t s;
    s = p >> (k * WL);
    return top ? s[D-1:0] : {1'b0, s[WL-1:0]};
  endfunction

  function automatic big_t eval_v(input logic [VW-1:0] v);
    big_t r;
    r = '0;
    for (int k = N - 1; k >= 0; k--) r = (r << WL) + big_t'(v[k*D +: D]);
    return r;
  endfunction

  function automatic logic [VW-1:0] to_words(input big_t x);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*D +: D] = word_of(x, k, k == N - 1);
    return v;
  endfunction

  // behavioural multi_mode_multiplier: full square, low half, or ceil high half plus add
  function automatic logic [2*VW-1:0] mul_model(input logic [2:0] ctl,
      input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [VW-1:0] add);
    big_t p, v;
    logic [2*VW-1:0] r;
    r = '0;
    p = eval_v(a) * eval_v(b);
    case (ctl)
      CTL_SQ: for (int k = 0; k < 2 * N; k++) r[k*D +: D] = word_of(p, k, k == 2 * N - 1);
      CTL_LO: for (int k = 0; k < N; k++) r[k*D +: D] = word_of(p, k, k == N - 1);
      CTL_HI: begin
        v = eval_v(add) + ((p + RM) >> (WL * N));
        for (int k = 0; k < N; k++) r[(N-1-k)*D +: D] = word_of(v, k, k == N - 1);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= mul_model(bus.o_mul_ctl, bus.o_mul_a, bus.o_mul_b, bus.o_mul_add);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.i_mul_dat = pipe[L-1];

  function automatic big_t golden(input big_t x, input int unsigned it, input big_t m,
                                  input big_t ri);
    big_t y;
    y = x % m;
    for (int unsigned i = 0; i < it; i++) y = ((y * y) % m) * ri % m;
    return y;
  endfunction

  function automatic big_t rand_x();
    big_t r;
    r = {$urandom, $urandom};
    return r % mod_m;
  endfunction

  function automatic big_t rand_mod();
    big_t r;
    r = {$urandom, $urandom};
    return (r >> 3) | (big_t'(1) << 60) | big_t'(1);
  endfunction

  task automatic chk(input string nm, input big_t act, input big_t want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic set_mod(input big_t m);
    big_t inv, t;
    inv = m;
    for (int i = 0; i < 6; i++) begin
      t   = (big_t'(2) - m * inv) & RM;
      inv = (inv * t) & RM;
    end
    mod_m  = m;
    nprime = (R - inv) & RM;
    rinv   = ((big_t'(1) + m * nprime) >> (WL * N)) % m;
    bus.i_modulus = to_words(m);
    bus.i_mod_inv = to_words(nprime);
  endtask

  task automatic start_run(input int unsigned it, input big_t x, input bit push,
                           output int unsigned dcyc);
    exp_t e;
    bus.i_iter  = it;
    bus.i_sq    = to_words(x);
    bus.i_start = 1'b1;
    e.s_cyc = cyc;
    e.d_cyc = cyc + 1 + it * RUN_LEN;
    e.m     = mod_m;
    e.want  = golden(x, it, mod_m, rinv);
    if (push) sb.push_back(e);
    dcyc = e.d_cyc;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_until(input int unsigned c);
    for (int i = 0; i < 5000 && cyc <= c; i++) @(negedge clk);
  endtask

  exp_t        ment;
  int unsigned t_off;
  logic [2:0]  ectl;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && cyc > sb[0].s_cyc) begin
        ment = sb[0];
        if (cyc < ment.d_cyc) begin
          t_off = cyc - ment.s_cyc - 1;
          ectl  = 3'b001 << ((t_off / (L + 1)) % 3);
          chk("run_busy", big_t'(bus.o_busy), 1);
          chk("run_done", big_t'(bus.o_done), 0);
          chk("run_ctl", big_t'(bus.o_mul_ctl), big_t'(ectl));
        end else begin
          chk("done_pulse", big_t'(bus.o_done), 1);
          chk("done_ctl", big_t'(bus.o_mul_ctl), big_t'(CTL_SQ));
          chk("result", eval_v(bus.o_sq) % ment.m, ment.want);
          void'(sb.pop_front());
        end
      end else begin
        chk("idle_done", big_t'(bus.o_done), 0);
        if (chk_idle) begin
          chk("idle_busy", big_t'(bus.o_busy), 0);
          chk("idle_ctl", big_t'(bus.o_mul_ctl), big_t'(CTL_SQ));
        end
      end
    end
  end

  initial begin
    int unsigned d;
    bit found;
    bus.i_start   = 1'b0;
    bus.i_iter    = '0;
    bus.i_sq      = '0;
    bus.i_modulus = '0;
    bus.i_mod_inv = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", big_t'(bus.o_busy), 0);
    chk("rst_done", big_t'(bus.o_done), 0);
    chk("rst_ctl", big_t'(bus.o_mul_ctl), big_t'(CTL_SQ));
    chk("rst_sq", big_t'(bus.o_sq), 0);
    chk("rst_a", big_t'(bus.o_mul_a), 0);
    chk("rst_b", big_t'(bus.o_mul_b), 0);
    chk("rst_add", big_t'(bus.o_mul_add), 0);
    rst_n    = 1'b1;
    chk_idle = 1'b1;

    set_mod(big_t'(64'hFFFF_FFFF_FFFF_FFC5));
    repeat (2) @(negedge clk);
    start_run(0, big_t'(5), 1'b1, d);
    wait_until(d);
    start_run(1, big_t'(3), 1'b1, d);
    wait_until(d);

    // multi-iteration runs need M < R/4 to keep the redundant value below 2M
    set_mod(rand_mod());
    for (int i = 0; i < 3; i++) begin
      start_run($urandom_range(2, 5), rand_x(), 1'b1, d);
      wait_until(d);
    end

    repeat (2) @(negedge clk);
    start_run(4, rand_x(), 1'b1, d);
    repeat (2) @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_iter  = 1;
    bus.i_sq    = to_words(rand_x());
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_until(d);

    set_mod(rand_mod());
    start_run(100, rand_x(), 1'b1, d);
    wait_until(d);

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_run($urandom_range(0, 6), rand_x(), 1'b1, d);
      wait_until(d);
    end

    chk_idle = 1'b0;
    start_run(3, rand_x(), 1'b0, d);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.o_mul_ctl == CTL_HI) found = 1'b1;
    end
    chk("hi_reached", big_t'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", big_t'(bus.o_mul_ctl), big_t'(CTL_SQ));
    chk("abort_busy", big_t'(bus.o_busy), 0);
    chk("abort_done", big_t'(bus.o_done), 0);
    chk("abort_sq", big_t'(bus.o_sq), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    chk_idle = 1'b1;
    repeat (30) @(negedge clk);

    start_run(2, rand_x(), 1'b1, d);
    wait_until(d);
    repeat (3) @(negedge clk);
    chk("sb_drained", big_t'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/redun_mont_seq.md
# redun_mont_seq

Sequencer that drives one `multi_mode_multiplier` instance through repeated redundant-form Montgomery squarings. Each squaring runs three multiplier passes: square, then low-half multiply by N', then high-half multiply by M with T_hi added. The block holds the working value, the intermediate T and m registers, the iteration counter and the start/done handshake. It sits directly upstream of the multiplier, drives its control and operand ports, and consumes its registered output.

## Interface
- `NUM_ELEMENTS`, 33, words per operand (N)
- `DSP_BIT_LEN`, 17, redundant word width
- `WORD_LEN`, 16, radix bits per word
- `MUL_LAT`, 1, cycles from multiplier operands to registered result (≥1)
- `ITER_W`, 32, iteration count width
- `i_clk` in 1: clock
- `i_rst_n` in 1: reset, asynchronous, active-low
- `i_start` in 1: start request; sampled only in IDLE
- `i_iter` in ITER_W: number of squarings; sampled with `i_start`
- `i_sq` in N×DSP_BIT_LEN: initial value; sampled with `i_start`
- `i_modulus` in N×DSP_BIT_LEN: M; held static while busy
- `i_mod_inv` in N×DSP_BIT_LEN: N' = −M⁻¹ mod R, with R = 2^(WORD_LEN·N); held static while busy
- `o_busy` out 1: high from the cycle after start acceptance until DONE
- `o_done` out 1: one-cycle pulse, result valid
- `o_sq` out N×DSP_BIT_LEN: working value
- `o_mul_ctl` out 3: one-hot multiplier mode
- `o_mul_a`, `o_mul_b`, `o_mul_add` out N×DSP_BIT_LEN: multiplier operands
- `i_mul_dat` in 2N×DSP_BIT_LEN: multiplier registered output

## Operation
**States:** IDLE, SQ, LO, HI, DONE.

**Phase timing**
- Each multiplier state lasts MUL_LAT+1 cycles, counted by `ph_cnt`.
- Operands and ctl are held constant for the whole phase.
- `i_mul_dat` is captured on the last cycle of the phase.

**IDLE**
- ctl=001; a, b and add are all 0.
- On `i_start`, load `sq` from `i_sq` and `cnt` from `i_iter`.
  - If `i_iter`=0: go to DONE.
  - Otherwise: go to SQ.

**SQ**
- ctl=001, a=b=sq, add=0.
- Capture: T_lo[k] = dat[k], T_hi[k] = dat[N+k], for k = 0..N−1.

**LO**
- ctl=010, a=T_lo, b=`i_mod_inv`, add=0.
- Capture: m[k] = dat[k].
- Bits above WORD_LEN−1 of m[N−1] are cleared (mod R).

**HI**
- ctl=100, a=m, b=`i_modulus`, add=T_hi.
- Capture: sq[k] = dat[N−1−k], because the multiplier outputs the high half in reversed word order.
- Decrement `cnt`.
  - If the new `cnt`=0: go to DONE.
  - Otherwise: go to SQ.

**DONE**
- Pulse `o_done`, then return to IDLE.

**Boundary conditions**
- `i_start` while not in IDLE is ignored.
- `o_mul_ctl` is always exactly one-hot, including in IDLE and during reset.
- Reset mid-operation aborts to IDLE; a partial result is not preserved.
- No modular reduction is applied to `sq`: it stays redundant, < 2M.

## Timing
**Reset values**
- State IDLE, `o_busy`=0, `o_done`=0, `o_mul_ctl`=001.
- `o_sq`, T_lo, T_hi, m and `cnt` reset to 0; a, b, add = 0.

**Latency**
- Start accepted at cycle 0.
- Each iteration takes 3·(MUL_LAT+1) cycles.
- `o_done` is high at cycle 1 + `i_iter`·3·(MUL_LAT+1).
- For `i_iter`=0, `o_done` is high at cycle 1.

**Output validity**
- `o_sq` is stable from the `o_done` cycle until the next accepted start.
- A start may be accepted the cycle after DONE, i.e. in IDLE.

**Ctl changes**
- `o_mul_ctl` changes only at phase boundaries, so the multiplier never sees a mid-phase mode switch.

## Structure
- Package `redun_mont_pkg` holds:
  - `state_t` enum (IDLE, SQ, LO, HI, DONE);
  - one-hot constants `CTL_SQ`=001, `CTL_LO`=010, `CTL_HI`=100.
- Sub-module `redun_mont_phase_cnt`: a MUL_LAT+1 modulo counter with a `last` flag. It clears on every state entry.

## Test plan
- **Reset mid-HI:** assert `i_rst_n`=0 during HI → next cycle: state IDLE, ctl=001, `o_busy`=0; `o_done` never pulses.
- **Zero iterations:** `i_iter`=0, `i_sq`=5 → `o_done` at cycle 1, `o_sq`=5, no ctl other than 001 observed.
- **Single squaring (N=4, M=0xFFFF_FFFF_FFFF_FFC5, behavioural multiplier model, MUL_LAT=1):** `i_iter`=1, `i_sq`=3 → `o_done` at cycle 7; value of `o_sq` mod M equals 9·R⁻¹ mod M.
- **Repeated squaring:** `i_iter`=100, random x, MUL_LAT=2 → `o_done` at cycle 901; `o_sq` mod M equals the golden Montgomery model result.
- **Start while busy:** pulse `i_start` with new `i_sq`/`i_iter` at cycle 3 of a run → ignored; the original result and timing are unchanged.
- **Back-to-back runs:** start in the IDLE cycle right after DONE → accepted; the ctl sequence 001,001,010,010,100,100 repeats per iteration with no glitch.
